risc_controller: RTL



---
 rtl/risc_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/risc_controller.sv
// risc_controller: instruction sequencer for the 8-bit RISC CPU.
//
// Steps a fixed 8-phase cycle per instruction and decodes the current phase,
// the instruction opcode and the ALU zero flag into the datapath strobes.
// A HLT instruction freezes the sequencer in OP_ADDR until reset.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_    in   asynchronous active-low reset
//   opcode  in   [2:0] opcode field of the instruction register
//   zero    in   ALU zero flag (accumulator == 0), used only in ALU_OP
//   sel     out  address mux select: 1 = PC, 0 = IR operand address
//   rd      out  memory read
//   ld_ir   out  load instruction register
//   inc_pc  out  increment PC
//   halt    out  CPU halted
//   ld_pc   out  load PC from IR operand
//   data_e  out  drive accumulator onto data bus
//   ld_ac   out  load accumulator from ALU out
//   wr      out  memory write
//   phase   out  [2:0] current phase (debug)
module risc_controller (
  input  logic       clk,
  input  logic       rst_,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    StInstAddr  = 3'd0,
    StInstFetch = 3'd1,
    StInstLoad  = 3'd2,
    StIdle      = 3'd3,
    StOpAddr    = 3'd4,
    StOpFetch   = 3'd5,
    StAluOp     = 3'd6,
    StStore     = 3'd7
  } phase_e;

  localparam logic [2:0] OpHlt = 3'b000;
  localparam logic [2:0] OpSkz = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpLda = 3'b101;
  localparam logic [2:0] OpSto = 3'b110;
  localparam logic [2:0] OpJmp = 3'b111;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;

  logic is_hlt, is_skz, is_sto, is_jmp, alu_op;
  logic hlt_now;

  assign is_hlt = (opcode == OpHlt);
  assign is_skz = (opcode == OpSkz);
  assign is_sto = (opcode == OpSto);
  assign is_jmp = (opcode == OpJmp);
  assign alu_op = (opcode == OpAdd) || (opcode == OpAnd) ||
                  (opcode == OpXor) || (opcode == OpLda);

  // HLT is recognised in OP_ADDR; the same edge that sets halted must also
  // hold the phase, otherwise the sequencer would slip into OP_FETCH.
  assign hlt_now = (phase_q == StOpAddr) && is_hlt;

  // State register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase_q  <= StInstAddr;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next state
  always_comb begin
    phase_d  = phase_e'(phase_q + 3'd1);
    halted_d = halted_q | hlt_now;
    if (halted_q || hlt_now) begin
      phase_d = StOpAddr;
    end
  end

  // Output decode
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;

    unique case (phase_q)
      StInstAddr: begin
        sel = 1'b1;
      end
      StInstFetch: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      StInstLoad, StIdle: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      StOpAddr: begin
        inc_pc = ~is_hlt;
        halt   = is_hlt;
      end
      StOpFetch: begin
        rd = alu_op;
      end
      StAluOp: begin
        rd     = alu_op;
        inc_pc = is_skz & zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      StStore: begin
        rd     = alu_op;
        ld_ac  = alu_op;
        inc_pc = is_jmp;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
    endcase

    // Once halted only the halt indication survives, whatever opcode now reads.
    if (halted_q) begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      halt   = 1'b1;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
    end
  end

  assign phase = phase_q;

endmodule
